// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds its predictor from received bits,
// declares lock, counts bit errors and flags loss of lock and stuck-at-zero links.
module prbs_checker #(
    parameter int TAP_A       = 2,
    parameter int TAP_B       = 3,
    parameter int LOCK_CNT    = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ZERO_LIMIT  = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             error,
    output logic             lock_lost,
    output logic             stuck_zero,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    localparam int FILL_W  = $clog2(TAP_B + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);
    localparam int ZERO_W  = $clog2(ZERO_LIMIT + 1);

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    state_t             r_state,     w_state_nx;
    logic [TAP_B:1]     r_hist,      w_hist_nx;
    logic [FILL_W-1:0]  r_fill,      w_fill_nx;
    logic [MATCH_W-1:0] r_match,     w_match_nx;
    logic [WIN_W-1:0]   r_win,       w_win_nx;
    logic [WERR_W-1:0]  r_werr,      w_werr_nx;
    logic [ZERO_W-1:0]  r_zero,      w_zero_nx;
    logic               r_error,     w_error_nx;
    logic               r_lock_lost, w_lock_lost_nx;
    logic               r_stuck,     w_stuck_nx;
    logic [CNT_W-1:0]   r_err_count, w_err_count_nx;
    logic [CNT_W-1:0]   r_bit_count, w_bit_count_nx;

    logic               w_pred;
    logic               w_mismatch;
    logic [WIN_W-1:0]   w_win_inc;
    logic [WERR_W-1:0]  w_werr_inc;
    logic [ZERO_W-1:0]  w_zero_inc;

    // Prediction always uses the history as it stood before this bit shifts in.
    assign w_pred     = r_hist[TAP_A] ^ r_hist[TAP_B];
    assign w_mismatch = din_valid & (din != w_pred);
    assign w_win_inc  = r_win + WIN_W'(1);
    assign w_werr_inc = r_werr + WERR_W'(w_mismatch);
    assign w_zero_inc = din ? '0 : r_zero + ZERO_W'(1);

    always_comb begin
        // NOTE: every next-state value gets its default first, so no path can infer a latch.
        w_state_nx     = r_state;
        w_hist_nx      = r_hist;
        w_fill_nx      = r_fill;
        w_match_nx     = r_match;
        w_win_nx       = r_win;
        w_werr_nx      = r_werr;
        w_zero_nx      = r_zero;
        w_error_nx     = 1'b0;
        w_lock_lost_nx = 1'b0;
        w_stuck_nx     = r_stuck;
        w_err_count_nx = r_err_count;
        w_bit_count_nx = r_bit_count;

        if (din_valid) begin
            w_hist_nx = {r_hist[TAP_B-1:1], din};
            case (r_state)
                ST_SEARCH: begin
                    if (r_fill != FILL_W'(TAP_B)) begin
                        w_fill_nx = r_fill + FILL_W'(1);
                    end else if (!w_mismatch && (r_hist != '0)) begin
                        if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
                            w_state_nx = ST_LOCKED;
                            w_match_nx = '0;
                            w_win_nx   = '0;
                            w_werr_nx  = '0;
                            w_zero_nx  = '0;
                        end else begin
                            w_match_nx = r_match + MATCH_W'(1);
                        end
                    end else begin
                        w_match_nx = '0;
                    end
                end
                ST_LOCKED: begin
                    if (r_bit_count != '1) w_bit_count_nx = r_bit_count + CNT_W'(1);
                    if (w_mismatch) begin
                        w_error_nx = 1'b1;
                        if (r_err_count != '1) w_err_count_nx = r_err_count + CNT_W'(1);
                    end
                    // Loss threshold and zero run may coincide; either way one lock_lost pulse.
                    if ((w_werr_inc == WERR_W'(LOSS_THRESH)) || (w_zero_inc == ZERO_W'(ZERO_LIMIT))) begin
                        w_state_nx     = ST_SEARCH;
                        w_lock_lost_nx = 1'b1;
                        w_match_nx     = '0;
                        w_win_nx       = '0;
                        w_werr_nx      = '0;
                        w_zero_nx      = '0;
                        if (w_zero_inc == ZERO_W'(ZERO_LIMIT)) w_stuck_nx = 1'b1;
                    end else begin
                        w_zero_nx = w_zero_inc;
                        if (w_win_inc == WIN_W'(WINDOW)) begin
                            w_win_nx  = '0;
                            w_werr_nx = '0;
                        end else begin
                            w_win_nx  = w_win_inc;
                            w_werr_nx = w_werr_inc;
                        end
                    end
                end
                default: w_state_nx = ST_SEARCH;
            endcase
        end

        if (clear_cnt) begin
            w_err_count_nx = '0;
            w_bit_count_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it takes effect only at a clock edge with reset_n low.
        if (!reset_n) begin
            r_state     <= ST_SEARCH;
            r_hist      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_werr      <= '0;
            r_zero      <= '0;
            r_error     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_stuck     <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_hist      <= w_hist_nx;
            r_fill      <= w_fill_nx;
            r_match     <= w_match_nx;
            r_win       <= w_win_nx;
            r_werr      <= w_werr_nx;
            r_zero      <= w_zero_nx;
            r_error     <= w_error_nx;
            r_lock_lost <= w_lock_lost_nx;
            r_stuck     <= w_stuck_nx;
            r_err_count <= w_err_count_nx;
            r_bit_count <= w_bit_count_nx;
        end
    end

    assign locked     = (r_state == ST_LOCKED);
    assign error      = r_error;
    assign lock_lost  = r_lock_lost;
    assign stuck_zero = r_stuck;
    assign err_count  = r_err_count;
    assign bit_count  = r_bit_count;

endmodule
